serial_add_ctrl: RTL and testbench

- Bit-serial add sequencer around one shared 1-bit adder datapath: two half-adder cells (sum = a^b, cout = a&b) plus one carry register, forming a full adder.
- Takes two WIDTH-bit operands and a carry-in on a start strobe.
- Steps the 1-bit datapath LSB-first, one bit per clock.
- Holds the WIDTH-bit sum and carry-out until the next operation is accepted.

---
 rtl/serial_add_ctrl.sv | 102 ++++++++++
 tb/tb_serial_add_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full adder (two half-adder cells plus a carry
// register) steps WIDTH-bit operands LSB-first and holds the result until the next start.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               cout_r;

    logic               s1;
    logic               c1;
    logic               s2;
    logic               c2;
    logic               accept;
    logic               last_bit;
    logic [WIDTH:0]     res_ext;

    // Full adder built from the two half-adder cells; carry is the registered third input.
    assign s1 = a_sh[0] ^ b_sh[0];
    assign c1 = a_sh[0] & b_sh[0];
    assign s2 = s1 ^ carry;
    assign c2 = s1 & carry;

    assign accept   = start && (state != RUN);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    // Widening by one bit lets the same shift expression work down to WIDTH=1.
    assign res_ext  = {s2, res};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res   <= res_ext[WIDTH:1];
            carry <= c1 | c2;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
                cout_r <= c1 | c2;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign sum  = res;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed plan plus randomized operations
// against an arithmetic reference (a + b + cin, fixed WIDTH+1 edge latency).
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation from IDLE or DONE; noisy mode keeps start high and
    // scrambles the operand inputs for the whole run, which must be ignored.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                       input bit noise);
        logic [8:0] exp;
        exp    = 9'(ia) + 9'(ib) + 9'(icin);
        start8 = 1'b1;
        a8     = ia;
        b8     = ib;
        cin8   = icin;
        step();
        check("accept_busy", 32'(busy8), 32'd1);
        check("accept_done", 32'(done8), 32'd0);
        for (int i = 1; i < 8; i++) begin
            if (noise) begin
                start8 = 1'b1;
                a8     = 8'($urandom);
                b8     = 8'($urandom);
                cin8   = 1'($urandom);
            end else begin
                start8 = 1'b0;
            end
            step();
            check("run_busy", 32'({busy8, done8}), 32'b10);
        end
        start8 = 1'b0;
        step();
        check("end_flags", 32'({busy8, done8}), 32'b01);
        check("end_result", 32'({cout8, sum8}), 32'(exp));
    endtask

    task automatic hold8(input int n, input logic [8:0] exp);
        start8 = 1'b0;
        for (int i = 0; i < n; i++) begin
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom);
            step();
            check("hold_flags", 32'({busy8, done8}), 32'b01);
            check("hold_result", 32'({cout8, sum8}), 32'(exp));
        end
    endtask

    task automatic op1(input logic ia, input logic ib, input logic icin);
        logic [1:0] exp;
        exp    = 2'(ia) + 2'(ib) + 2'(icin);
        start1 = 1'b1;
        a1     = ia;
        b1     = ib;
        cin1   = icin;
        step();
        check("w1_busy", 32'({busy1, done1}), 32'b10);
        start1 = 1'b0;
        a1     = ~ia;
        b1     = ~ib;
        cin1   = ~icin;
        step();
        check("w1_done", 32'({busy1, done1}), 32'b01);
        check("w1_result", 32'({cout1, sum1}), 32'(exp));
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] last;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        step();
        step();
        check("rst_flags", 32'({busy8, done8}), 32'b00);
        check("rst_result", 32'({cout8, sum8}), 32'h0);
        check("rst_w1", 32'({busy1, done1, cout1, sum1}), 32'h0);
        rst = 1'b0;
        step();
        check("idle_flags", 32'({busy8, done8}), 32'b00);

        op8(8'h3C, 8'h5A, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1, 1'b0);
        op8(8'h10, 8'h20, 1'b0, 1'b1);
        check("ignored_start", 32'({cout8, sum8}), 32'h030);
        op8(8'h80, 8'h80, 1'b1, 1'b0);
        hold8(5, 9'h101);

        // Reset lands on E4 of a running operation.
        start8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        step();
        start8 = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        check("abort_flags", 32'({busy8, done8}), 32'b00);
        check("abort_result", 32'({cout8, sum8}), 32'h0);
        rst = 1'b0;
        step();
        check("abort_idle", 32'({busy8, done8}), 32'b00);
        op8(8'h01, 8'h02, 1'b0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check("rnd_rst", 32'({busy8, done8, cout8, sum8}), 32'h0);
            end
            op8(ra, rb, rc, 1'($urandom));
            last = 9'(ra) + 9'(rb) + 9'(rc);
            hold8(int'($urandom_range(0, 3)), last);
        end

        for (int k = 0; k < 8; k++) begin
            op1(k[2], k[1], k[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
